// File: rtl/reg_writeback_ctrl.sv
// ============================================================================
// Module     : reg_writeback_ctrl
// Description: Register-file writeback arbiter. ALU results take priority;
//              memory results wait in a FIFO and drain when the ALU is idle.
//              Optional macro WB_DROP_R31_EN suppresses writes to R31.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback_ctrl #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          alu_valid,
    input  logic [4:0]    alu_add,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [4:0]    mem_add,
    input  logic [31:0]   mem_data,
    output logic          write_enable,
    output logic [4:0]    write_add,
    output logic [31:0]   write_data,
    output logic [CW-1:0] pending
);

    localparam int            AW     = (CW > 1) ? CW - 1 : 1;
    localparam logic [CW-1:0] c_full = CW'(DEPTH);

    logic [36:0]   slot_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q;

    logic          push_w, pop_w;
    logic [36:0]   head_w;
    logic          alu_drop_w, mem_drop_w;
    logic          we_d;
    logic [4:0]    add_d;
    logic [31:0]   data_d;

    // ready_q keeps mem_ready low through reset and the cycle it releases.
    assign mem_ready = ready_q & (count_q < c_full);
    assign push_w    = mem_valid & mem_ready;
    assign pop_w     = ~alu_valid & (count_q != '0);
    assign head_w    = slot_q[rd_ptr_q];
    assign pending   = count_q;

`ifdef WB_DROP_R31_EN
    assign alu_drop_w = (alu_add == 5'd31);
    assign mem_drop_w = (head_w[36:32] == 5'd31);
`else
    assign alu_drop_w = 1'b0;
    assign mem_drop_w = 1'b0;
`endif

    always_comb begin
        we_d   = 1'b0;
        add_d  = write_add;
        data_d = write_data;
        if (alu_valid) begin
            if (!alu_drop_w) begin
                we_d   = 1'b1;
                add_d  = alu_add;
                data_d = alu_data;
            end
        end else if (pop_w) begin
            if (!mem_drop_w) begin
                we_d   = 1'b1;
                add_d  = head_w[36:32];
                data_d = head_w[31:0];
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_w) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_w) - CW'(pop_w);
    end

    always_ff @(posedge clk) begin
        if (push_w) begin
            slot_q[wr_ptr_q] <= {mem_add, mem_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ready_q      <= 1'b0;
            write_enable <= 1'b0;
            write_add    <= '0;
            write_data   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ready_q      <= 1'b1;
            write_enable <= we_d;
            write_add    <= add_d;
            write_data   <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback_ctrl.sv
// ============================================================================
// Module     : tb_reg_writeback_ctrl
// Description: Directed and random checks of reg_writeback_ctrl against a
//              queue-based reference model.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback_ctrl;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          alu_valid;
    logic [4:0]    alu_add;
    logic [31:0]   alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_add;
    logic [31:0]   mem_data;
    logic          write_enable;
    logic [4:0]    write_add;
    logic [31:0]   write_data;
    logic [CW-1:0] pending;

    reg_writeback_ctrl #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_add      (alu_add),
        .alu_data     (alu_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_add      (mem_add),
        .mem_data     (mem_data),
        .write_enable (write_enable),
        .write_add    (write_add),
        .write_data   (write_data),
        .pending      (pending)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [36:0] model_q [$];
    logic        m_ready;
    logic        m_we;
    logic [4:0]  m_add;
    logic [31:0] m_data;
    logic        m_accept;

    function automatic bit drops(input logic [4:0] a);
`ifdef WB_DROP_R31_EN
        return a == 5'd31;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".we"},      32'(write_enable), 32'(m_we));
        chk({tag, ".add"},     32'(write_add),    32'(m_add));
        chk({tag, ".data"},    write_data,        m_data);
        chk({tag, ".pending"}, 32'(pending),      32'(model_q.size()));
        chk({tag, ".ready"},   32'(mem_ready),
            32'(m_ready && (model_q.size() < DEPTH)));
    endtask

    // One rising edge: predict from the spec rules, clock, then compare.
    task automatic tick(input string tag);
        logic [36:0] e;
        m_accept = mem_valid && m_ready && (model_q.size() < DEPTH);
        if (alu_valid) begin
            m_we = 1'b0;
            if (!drops(alu_add)) begin
                m_we   = 1'b1;
                m_add  = alu_add;
                m_data = alu_data;
            end
        end else if (model_q.size() > 0) begin
            e    = model_q.pop_front();
            m_we = 1'b0;
            if (!drops(e[36:32])) begin
                m_we   = 1'b1;
                m_add  = e[36:32];
                m_data = e[31:0];
            end
        end else begin
            m_we = 1'b0;
        end
        if (m_accept) model_q.push_back({mem_add, mem_data});
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        m_ready = 1'b0;
        m_we    = 1'b0;
        m_add   = '0;
        m_data  = '0;
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset     = 1'b1;
        alu_valid = 1'b0;
        alu_add   = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_add   = '0;
        mem_data  = '0;
        model_reset();
        m_accept  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 32'(mem_ready), 32'd0);
        tick("post_reset");
        chk("ready_after_edge", 32'(mem_ready), 32'd1);

        // ALU write, one-cycle latency, then strobe drops with data held
        alu_valid = 1'b1; alu_add = 5'd5; alu_data = 32'hDEADBEEF;
        tick("alu_write");
        idle();
        tick("alu_idle");
        chk("alu_hold_data", write_data, 32'hDEADBEEF);

        // Memory push then pop on the following edge
        mem_valid = 1'b1; mem_add = 5'd7; mem_data = 32'h11;
        tick("mem_push");
        chk("mem_push_pending", 32'(pending), 32'd1);
        idle();
        tick("mem_pop");
        chk("mem_pop_add", 32'(write_add), 32'd7);

        // Queue fills under continuous ALU traffic, then drains in order
        k = 0;
        alu_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            alu_add   = 5'(1 + c);
            alu_data  = 32'hA000 + 32'(c);
            mem_valid = (k < 5);
            mem_add   = 5'(8 + k);
            mem_data  = 32'h100 + 32'(k);
            tick("full_fill");
            if (m_accept) k++;
        end
        chk("full_pending", 32'(pending), 32'd4);
        chk("full_ready", 32'(mem_ready), 32'd0);
        idle();
        for (int i = 0; i < 4; i++) begin
            tick("drain");
            chk("drain_order", 32'(write_add), 32'(8 + i));
        end
        tick("drain_empty");

        // Simultaneous push/pop with two entries held, across pointer wrap
        alu_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            mem_valid = 1'b1; mem_add = 5'(20 + i); mem_data = 32'h200 + 32'(i);
            tick("pp_fill");
        end
        alu_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1'b1; mem_add = 5'(22 + i); mem_data = 32'h300 + 32'(i);
            tick("pp_steady");
            chk("pp_pending", 32'(pending), 32'd2);
        end
        idle();
        repeat (2) tick("pp_drain");

        // Asynchronous reset with three entries queued
        alu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_add = 5'd3; alu_data = 32'(i);
            mem_valid = 1'b1; mem_add = 5'(12 + i); mem_data = 32'h400 + 32'(i);
            tick("rst_fill");
        end
        chk("rst_fill_pending", 32'(pending), 32'd3);
        idle();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #3;
        reset = 1'b0;
        repeat (3) tick("after_reset");

        // R31 handling depends on the build option
        alu_valid = 1'b1; alu_add = 5'd31; alu_data = 32'h5;
        tick("r31_alu");
`ifdef WB_DROP_R31_EN
        chk("r31_we", 32'(write_enable), 32'd0);
`else
        chk("r31_we", 32'(write_enable), 32'd1);
        chk("r31_data", write_data, 32'h5);
`endif
        alu_valid = 1'b0;
        mem_valid = 1'b1; mem_add = 5'd31; mem_data = 32'h77;
        tick("r31_push");
        idle();
        tick("r31_pop");

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_add   = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            mem_valid = ($urandom_range(0, 1) == 1);
            mem_add   = 5'($urandom_range(0, 31));
            mem_data  = $urandom;
            tick("random");
        end
        idle();
        repeat (DEPTH + 1) tick("final_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
